// File: rtl/mvm_result_collector.sv
// Captures N multiplier results after each done pulse, requantizes them and queues them with a last flag.
// First result is valid two cycles after done; a vector is dropped (sticky overflow) when the FIFO cannot hold it whole.
module mvm_result_collector #(
  parameter int N     = 8,
  parameter int IN_W  = 16,
  parameter int OUT_W = 8,
  parameter int SHIFT = 4,
  parameter int RELU  = 1,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       done,
  input  logic [IN_W-1:0]            data_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic                       out_last,
  output logic                       stall,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW   = (N > 1) ? $clog2(N) : 1;
  localparam int RNDI = 1 << (SHIFT - 1);
  localparam int MAXI = (1 << (OUT_W - 1)) - 1;
  localparam int MINI = -(1 << (OUT_W - 1));
  localparam logic signed [IN_W:0] RND  = RNDI[IN_W:0];
  localparam logic signed [IN_W:0] MAXV = MAXI[IN_W:0];
  localparam logic signed [IN_W:0] MINV = MINI[IN_W:0];

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DROP} state_t;

  state_t            r_state, w_state_nxt;
  logic [NW-1:0]     r_cnt;
  logic              r_overflow;
  logic [CW-1:0]     r_count;
  logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [OUT_W:0]    r_mem [DEPTH];
  logic [OUT_W-1:0]  r_hold;

  logic              w_push, w_pop, w_set_ovf, w_last_elem;
  logic [CW-1:0]     w_free;
  logic signed [IN_W:0] w_sum, w_shr, w_relu;
  logic [OUT_W-1:0]  w_q;

  assign w_last_elem = (r_cnt == NW'(N - 1));
  assign w_free      = CW'(DEPTH) - r_count;

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_set_ovf   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (done) begin
          if (w_free >= CW'(N)) begin
            w_state_nxt = S_CAPTURE;
          end else begin
            w_state_nxt = S_DROP;
            w_set_ovf   = 1'b1;
          end
        end
      end
      S_CAPTURE: begin
        w_push = 1'b1;
        if (w_last_elem) w_state_nxt = S_IDLE;
      end
      S_DROP: begin
        if (w_last_elem) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state != S_IDLE) r_cnt <= w_last_elem ? '0 : r_cnt + 1'b1;
      if (w_set_ovf) r_overflow <= 1'b1;
    end
  end

  // Adding half an LSB before the arithmetic shift rounds half toward +inf.
  assign w_sum  = $signed({data_in[IN_W-1], data_in}) + RND;
  assign w_shr  = w_sum >>> SHIFT;
  assign w_relu = ((RELU != 0) && w_shr[IN_W]) ? '0 : w_shr;

  always_comb begin
    w_q = w_relu[OUT_W-1:0];
    if (w_relu > MAXV)      w_q = MAXV[OUT_W-1:0];
    else if (w_relu < MINV) w_q = MINV[OUT_W-1:0];
  end

  assign w_pop = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_last_elem, w_q};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_hold   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
        r_hold   <= r_mem[r_rd_ptr][OUT_W-1:0];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Once empty, the last popped value is presented rather than a stale slot.
  assign out_valid  = (r_count != '0);
  assign out_data   = out_valid ? r_mem[r_rd_ptr][OUT_W-1:0] : r_hold;
  assign out_last   = out_valid & r_mem[r_rd_ptr][OUT_W];
  assign stall      = (w_free < CW'(N));
  assign overflow   = r_overflow;
  assign fifo_count = r_count;
endmodule

// File: tb/tb_mvm_result_collector.sv
// Directed and randomized checks of mvm_result_collector against a queue-based reference model.
module tb_mvm_result_collector;
  localparam int N = 8, IN_W = 16, OUT_W = 8, SHIFT = 4, DEPTH = 16;
  localparam int CW = $clog2(DEPTH + 1);

  logic clk = 1'b0, rst = 1'b0;
  logic done = 1'b0, out_ready = 1'b0;
  logic [IN_W-1:0] data_in = '0;
  logic out_valid, out_last, stall, overflow;
  logic [OUT_W-1:0] out_data;
  logic [CW-1:0] fifo_count;

  logic done0 = 1'b0, ready0 = 1'b1;
  logic [IN_W-1:0] data0 = '0;
  logic valid0, last0, stall0, ovf0;
  logic [OUT_W-1:0] odata0;
  logic [CW-1:0] count0;

  int ncomp = 0, nfail = 0;
  bit mon_en = 1'b0, rnd_rdy = 1'b0;

  mvm_result_collector #(.N(N), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .RELU(1), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .reset(rst), .done(done), .data_in(data_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .stall(stall),
    .overflow(overflow), .fifo_count(fifo_count));

  mvm_result_collector #(.N(N), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .RELU(0), .DEPTH(DEPTH)) u_dut0 (
    .clk(clk), .reset(rst), .done(done0), .data_in(data0), .out_valid(valid0),
    .out_ready(ready0), .out_data(odata0), .out_last(last0), .stall(stall0),
    .overflow(ovf0), .fifo_count(count0));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // floor((x + 2^(SHIFT-1)) / 2^SHIFT), then optional ReLU and clamp to the output range
  function automatic int requant(input int x, input bit relu);
    int num = x + (1 << (SHIFT - 1));
    int d = 1 << SHIFT;
    int q = num / d;
    if ((num % d) != 0 && num < 0) q--;
    if (relu && q < 0) q = 0;
    if (q > (1 << (OUT_W - 1)) - 1) q = (1 << (OUT_W - 1)) - 1;
    if (q < -(1 << (OUT_W - 1))) q = -(1 << (OUT_W - 1));
    return q;
  endfunction

  typedef struct { int data; bit last; } ent_t;
  ent_t mq[$];
  int m_mode = 0, m_rem = 0, m_hold = 0;
  bit m_ovf = 1'b0;

  always @(negedge clk) begin
    int sz, free;
    ent_t e;
    sz = mq.size();
    if (mon_en) begin
      check("m_valid", out_valid, (sz > 0));
      check("m_count", fifo_count, sz);
      check("m_stall", stall, ((DEPTH - sz) < N));
      check("m_overflow", overflow, m_ovf);
      if (sz > 0) begin
        check("m_data", $signed(out_data), mq[0].data);
        check("m_last", out_last, mq[0].last);
      end else begin
        check("m_hold", $signed(out_data), m_hold);
      end
    end
    if (!rst) begin
      mq.delete();
      m_mode = 0; m_rem = 0; m_hold = 0; m_ovf = 1'b0;
    end else begin
      free = DEPTH - sz;
      if (sz > 0 && out_ready) begin
        e = mq.pop_front();
        m_hold = e.data;
      end
      case (m_mode)
        0: if (done) begin
          m_rem = N;
          if (free >= N) m_mode = 1;
          else begin m_mode = 2; m_ovf = 1'b1; end
        end
        1: begin
          e.data = requant(int'($signed(data_in)), 1'b1);
          e.last = (m_rem == 1);
          mq.push_back(e);
          m_rem--;
          if (m_rem == 0) m_mode = 0;
        end
        default: begin
          m_rem--;
          if (m_rem == 0) m_mode = 0;
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  function automatic logic [IN_W-1:0] rnd_data();
    int v;
    if ($urandom_range(0, 1) == 1) v = int'($urandom_range(0, 65535));
    else v = int'($urandom_range(0, 4095)) - 2048;
    return IN_W'(v);
  endfunction

  // Drives done then N elements; optional abort (reset low), re-done, ready-raise and count-hold check.
  task automatic send(input int abort_at, input int redone_at, input int rdy_at, input bit chk8);
    tick();
    done = 1'b1;
    data_in = rnd_data();
    for (int j = 0; j < N; j++) begin
      tick();
      done = (j == redone_at);
      data_in = rnd_data();
      if (j == rdy_at) out_ready = 1'b1;
      if (chk8) check("conc_count", fifo_count, 8);
      if (j == abort_at) begin
        rst = 1'b0;
        done = 1'b0;
        return;
      end
    end
    tick();
    done = 1'b0;
    data_in = rnd_data();
  endtask

  int basic_in[N] = '{160, -50, 24, 32767, 7, 8, -1, 0};
  int basic_ex[N] = '{10, 0, 2, 127, 0, 1, 0, 0};
  int r0_in[N]    = '{-50, -32768, -8, -9, 0, 0, 0, 0};
  int r0_ex[N]    = '{-3, -128, 0, -1, 0, 0, 0, 0};

  initial begin
    tick();
    tick();
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_count", fifo_count, 0);
    check("rst_stall", stall, 0);
    check("rst_data", out_data, 0);
    check("rst_overflow", overflow, 0);
    mon_en = 1'b1;
    rst = 1'b1;
    tick();

    // basic vector on the RELU instance, signed/saturating vector on the RELU=0 instance
    out_ready = 1'b1;
    tick();
    done = 1'b1; done0 = 1'b1;
    check("lat_c0", out_valid, 0);
    for (int j = 0; j <= N; j++) begin
      tick();
      done = 1'b0; done0 = 1'b0;
      if (j < N) begin
        data_in = IN_W'(basic_in[j]);
        data0 = IN_W'(r0_in[j]);
      end else begin
        data_in = '0;
        data0 = '0;
      end
      if (j == 0) begin
        check("lat_c1", out_valid, 0);
      end else begin
        check("basic_valid", out_valid, 1);
        check("basic_data", $signed(out_data), basic_ex[j-1]);
        check("basic_last", out_last, (j == N));
        check("relu0_valid", valid0, 1);
        check("relu0_data", $signed(odata0), r0_ex[j-1]);
      end
    end
    tick();
    check("basic_empty", out_valid, 0);
    check("basic_hold", $signed(out_data), basic_ex[N-1]);

    // back-pressure: two vectors fill the FIFO, the third is dropped
    out_ready = 1'b0;
    send(-1, -1, -1, 1'b0);
    send(-1, -1, -1, 1'b0);
    tick();
    check("bp_count", fifo_count, 16);
    check("bp_stall", stall, 1);
    check("bp_ovf_before", overflow, 0);
    send(-1, -1, -1, 1'b0);
    tick();
    check("bp_ovf", overflow, 1);
    check("bp_count_drop", fifo_count, 16);
    out_ready = 1'b1;
    repeat (18) tick();
    check("bp_drained", fifo_count, 0);

    // concurrent push/pop keeps the count steady
    out_ready = 1'b0;
    send(-1, -1, -1, 1'b0);
    send(-1, -1, 0, 1'b1);
    check("conc_end", fifo_count, 8);
    repeat (10) tick();
    check("conc_drained", fifo_count, 0);

    // done re-asserted mid-capture is ignored
    out_ready = 1'b0;
    send(-1, 4, -1, 1'b0);
    repeat (3) tick();
    check("redone_count", fifo_count, 8);
    out_ready = 1'b1;
    repeat (10) tick();

    // reset in the middle of a capture
    out_ready = 1'b0;
    send(3, -1, -1, 1'b0);
    tick();
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ovf", overflow, 0);
    rst = 1'b1;
    send(-1, -1, -1, 1'b0);
    tick();
    check("mid_rst_fresh", fifo_count, 8);
    out_ready = 1'b1;
    repeat (10) tick();

    // randomized traffic with random consumer readiness
    rnd_rdy = 1'b1;
    for (int v = 0; v < 30; v++) begin
      send(-1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1, -1, 1'b0);
      repeat ($urandom_range(0, 2)) tick();
    end
    rnd_rdy = 1'b0;
    out_ready = 1'b1;
    repeat (20) tick();
    check("rand_drained", fifo_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end
endmodule

// File: doc/mvm_result_collector.md
Name: mvm_result_collector

Overview:
- Downstream stage of the mvm_8_1_8_1 matrix-vector multiplier.
- Watches the multiplier's done pulse and captures the N signed results streamed on its data_out, one per cycle.
- Requantizes each result (rounding arithmetic right shift, optional ReLU, saturation to OUT_W) and buffers it in a FIFO.
- Presents results on a valid/ready stream, with a last flag per vector and a stall signal toward the upstream start sequencer.

Parameters:
- N, 8: results per vector (matrix rows).
- IN_W, 16: width of multiplier output (2 x multiplier input width).
- OUT_W, 8: width of requantized output.
- SHIFT, 4: right-shift amount, 1..IN_W-1.
- RELU, 1: 1 clamps negative results to 0; 0 passes them.
- DEPTH, 16: FIFO entries; must be >= N.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low (0 resets on the clock edge).
- done  in  1  multiplier done, sampled each rising edge.
- data_in  in  IN_W  signed multiplier result (multiplier data_out).
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_data  out  OUT_W  signed requantized result at FIFO head.
- out_last  out  1  head is element N-1 of its vector.
- stall  out  1  high when FIFO free entries < N; upstream must not assert start.
- overflow  out  1  sticky: a vector was dropped.
- fifo_count  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Reset (reset==0 at edge): state IDLE, FIFO emptied, capture counter 0, overflow 0. Resulting outputs: out_valid 0, out_last 0, fifo_count 0, stall 0, out_data 0. Reset mid-capture aborts the capture; partial elements are discarded.
- Timing: done high in cycle c0 means element j (0..N-1) is on data_in in cycle c0+1+j and is captured at the edge ending that cycle.
- State machine:
  - IDLE: on done==1, go to CAPTURE if free entries >= N, otherwise go to DROP and set overflow.
  - CAPTURE: push one processed element per cycle for N cycles, then IDLE. done asserted during CAPTURE is ignored.
  - DROP: discard N cycles of data_in, then IDLE. FIFO contents are unchanged.
  - Exit on the last element returns to IDLE; a done on the following cycle is honoured.
- Arithmetic, per element:
  - Sign-extend to IN_W+1 bits and add 2^(SHIFT-1).
  - Arithmetic right shift by SHIFT (round half up, toward +inf).
  - If RELU==1, clamp negatives to 0.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- out_last: stored alongside each element in the FIFO (OUT_W+1-bit entries); set only on element j=N-1.
- FIFO:
  - Push occurs in CAPTURE. Pop occurs when out_valid && out_ready.
  - Simultaneous push and pop leave fifo_count unchanged.
  - Read/write pointers wrap modulo DEPTH.
  - Admission reserves N entries, so a push never hits full.
  - Latency: a captured element is visible at the head on the cycle after capture if the FIFO was empty. First out_valid occurs in cycle c0+2.
- out_data/out_last: come from registered storage and hold stable while out_valid && !out_ready. When empty, out_valid is 0 and out_data holds the last value.
- stall: combinational from fifo_count (DEPTH - fifo_count < N); not reserved-count aware.
- overflow: sticky; cleared only by reset.

Test Plan:
- Basic (defaults): done, then data_in 160,-50,24,32767,7,8,-1,0 with out_ready=1 -> out_data 10,0,2,127,0,1,0,0. out_valid first high in cycle c0+2. out_last only with the 8th.
- RELU=0, data_in -50, -32768, -8, -9 -> out_data -3, -128, 0, -1 (floor-based rounding, saturation).
- Back-pressure: out_ready=0, two vectors -> fifo_count 16, stall=1. Third done -> DROP, overflow=1, fifo_count stays 16. Draining returns the first two vectors intact in order.
- Concurrency: out_ready=1 while capturing a second vector with 8 entries queued -> fifo_count stays 8 during capture. Order is preserved across pointer wrap.
- Reset mid-capture: reset=0 at element 3 -> fifo_count 0, out_valid 0, overflow 0. A following done captures a fresh full vector.
- done re-asserted at element 4 during CAPTURE -> ignored; exactly 8 entries pushed.
